uart8_receiver: RTL and testbench

- 8-bit UART receiver: 1 start bit, 8 data bits LSB first, 1 stop bit.
- Downstream consumer of the TX line driven by our 8-bit transmitter.
- Oversamples the serial line, recovers bytes and presents them on a valid/ready handshake with a one-byte holding register.
- Flags framing errors and overruns.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_tick.sv | 33 +++
 rtl/uart8_receiver.sv | 164 ++++++++++++++++
 tb/tb_uart8_receiver.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, FSM state encoding and baud divider helper.
package uart_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned BIT_IDX_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        PARITY_BIT,
        STOP_BIT,
        WAIT_IDLE
    } uart_state_e;

    // Clocks per oversample tick (integer divide).
    function automatic int unsigned baud_div(input int unsigned clock_rate,
                                             input int unsigned baud_rate,
                                             input int unsigned oversample);
        return clock_rate / (baud_rate * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks, held in phase by a synchronous clear.
module uart_baud_tick #(
    parameter int unsigned DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = (DIV < 2) ? 1 : $clog2(DIV);

    if (DIV < 2) begin : g_div_check
        $error("uart_baud_tick: DIV must be at least 2");
    end

    logic [CNT_W-1:0] cnt;

    // tick is registered but lands in the cycle where cnt == DIV-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clear) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= (cnt == CNT_W'(DIV - 1)) ? '0 : cnt + 1'b1;
            tick <= (cnt == CNT_W'(DIV - 2));
        end
    end

endmodule

// File: rtl/uart8_receiver.sv
// 8N1 UART receiver with oversampling, valid/ready holding register, framing and overrun flags.
// Optional even-parity bit and parity_err output when UART_RX_PARITY_EN is defined.
module uart8_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_RATE = 50000000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              in,
    output logic [DATA_W-1:0] out,
    output logic              valid,
    input  logic              ready,
    output logic              frame_err,
`ifdef UART_RX_PARITY_EN
    output logic              parity_err,
`endif
    output logic              overrun
);

    localparam int unsigned DIV   = baud_div(CLOCK_RATE, BAUD_RATE, OVERSAMPLE);
    localparam int unsigned SUB_W = $clog2(OVERSAMPLE);

    if (OVERSAMPLE < 8 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_os_check
        $error("uart8_receiver: OVERSAMPLE must be a power of 2 and at least 8");
    end

    uart_state_e          state, state_next;
    logic                 sync1, rx_s, rx_prev;
    logic                 tick;
    logic [SUB_W-1:0]     sub;
    logic [BIT_IDX_W-1:0] bit_idx;
    logic [DATA_W-1:0]    shift;
    logic                 rx_fall_c, half_end_c, bit_end_c;
    logic                 deliver_c, ferr_c;
`ifdef UART_RX_PARITY_EN
    logic                 perr_c, parity_bad;
`endif

    assign rx_fall_c  = rx_prev & ~rx_s;
    assign half_end_c = tick && (sub == SUB_W'(OVERSAMPLE / 2 - 1));
    assign bit_end_c  = tick && (sub == SUB_W'(OVERSAMPLE - 1));

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .rst_n (reset),
        .clear (state == IDLE),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        deliver_c  = 1'b0;
        ferr_c     = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_c     = 1'b0;
`endif
        case (state)
            IDLE:      if (en && rx_fall_c) state_next = START_BIT;
            START_BIT: if (half_end_c) state_next = rx_s ? IDLE : DATA_BITS;
            DATA_BITS: begin
                if (bit_end_c && bit_idx == BIT_IDX_W'(DATA_W - 1)) begin
`ifdef UART_RX_PARITY_EN
                    state_next = PARITY_BIT;
`else
                    state_next = STOP_BIT;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY_BIT: begin
                if (bit_end_c) begin
                    perr_c     = rx_s ^ (^shift);
                    state_next = STOP_BIT;
                end
            end
`endif
            STOP_BIT: begin
                if (bit_end_c) begin
                    if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                        deliver_c = ~parity_bad;
`else
                        deliver_c = 1'b1;
`endif
                        state_next = IDLE;
                    end else begin
                        ferr_c     = 1'b1;
                        state_next = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: if (rx_s) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
        // Disable wins over everything, including a same-cycle delivery or error.
        if (!en) begin
            state_next = IDLE;
            deliver_c  = 1'b0;
            ferr_c     = 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_c     = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1      <= 1'b1;
            rx_s       <= 1'b1;
            rx_prev    <= 1'b1;
            sub        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            out        <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
            parity_bad <= 1'b0;
`endif
        end else begin
            sync1   <= in;
            rx_s    <= sync1;
            rx_prev <= rx_s;

            // Sub-bit phase restarts on every state change so each state times from its own entry.
            if (state_next != state) sub <= '0;
            else if (tick)           sub <= sub + 1'b1;

            if (state != DATA_BITS) bit_idx <= '0;
            else if (bit_end_c)     bit_idx <= bit_idx + 1'b1;

            if (state == DATA_BITS && bit_end_c) shift[bit_idx] <= rx_s;

            frame_err <= ferr_c;
            overrun   <= 1'b0;
            if (valid && ready) valid <= 1'b0;
            if (deliver_c) begin
                if (!valid || ready) begin
                    out   <= shift;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            parity_err <= perr_c;
            if (state == START_BIT) parity_bad <= 1'b0;
            else if (perr_c)        parity_bad <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_uart8_receiver.sv
// Directed bench for uart8_receiver at DIV=10, 160 clocks per bit.
module tb_uart8_receiver;

    localparam int unsigned BIT_CLKS = 160;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b1;
    logic       in = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] out;
    logic       valid, frame_err, overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int total = 0;
    int bad = 0;

    uart8_receiver #(
        .CLOCK_RATE (1600000),
        .BAUD_RATE  (10000),
        .OVERSAMPLE (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .in         (in),
        .out        (out),
        .valid      (valid),
        .ready      (ready),
        .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_valid = 0, n_ferr = 0, n_ovr = 0, n_perr = 0, last_valid_cyc = 0;
    logic [7:0] last_out = 8'h00;
    logic       valid_q = 1'b0;

    always @(negedge clk) begin
        if (valid && !valid_q) begin
            n_valid++;
            last_out       = out;
            last_valid_cyc = cyc;
        end
        valid_q = valid;
        if (frame_err) n_ferr++;
        if (overrun)   n_ovr++;
`ifdef UART_RX_PARITY_EN
        if (parity_err) n_perr++;
`endif
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold_bit(input logic b);
        in = b;
        idle(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        hold_bit(^d);
`endif
        hold_bit(stop);
    endtask

    task automatic test_reset();
        idle(3);
        total++; if (out !== 8'h00)     begin bad++; $display("FAIL reset_out got=%h exp=00", out); end
        total++; if (valid !== 1'b0)    begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
        total++; if (overrun !== 1'b0)  begin bad++; $display("FAIL reset_ovr got=%b exp=0", overrun); end
        reset = 1'b1;
        idle(20);
    endtask

    task automatic test_single();
        int v0 = n_valid, f0 = n_ferr, o0 = n_ovr, c0;
        c0 = cyc;
        send_frame(8'hA5, 1'b1);
        idle(50);
        total++; if (n_valid - v0 !== 1) begin bad++; $display("FAIL single_nvalid got=%0d exp=1", n_valid - v0); end
        total++; if (last_out !== 8'hA5) begin bad++; $display("FAIL single_out got=%h exp=a5", last_out); end
        total++; if (n_ferr - f0 !== 0)  begin bad++; $display("FAIL single_ferr got=%0d exp=0", n_ferr - f0); end
        total++; if (n_ovr - o0 !== 0)   begin bad++; $display("FAIL single_ovr got=%0d exp=0", n_ovr - o0); end
        total++;
        if (last_valid_cyc - c0 < 1522 || last_valid_cyc - c0 > 1525) begin
            bad++; $display("FAIL single_latency got=%0d exp=1522..1525", last_valid_cyc - c0);
        end
        total++; if (valid !== 1'b0)     begin bad++; $display("FAIL single_consumed got=%b exp=0", valid); end
    endtask

    task automatic test_back_to_back();
        int v0 = n_valid, o0 = n_ovr;
        ready = 1'b0;
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        idle(100);
        total++; if (valid !== 1'b1)     begin bad++; $display("FAIL b2b_valid got=%b exp=1", valid); end
        total++; if (out !== 8'h3C)      begin bad++; $display("FAIL b2b_out got=%h exp=3c", out); end
        total++; if (n_valid - v0 !== 1) begin bad++; $display("FAIL b2b_nvalid got=%0d exp=1", n_valid - v0); end
        total++; if (n_ovr - o0 !== 1)   begin bad++; $display("FAIL b2b_ovr got=%0d exp=1", n_ovr - o0); end
        ready = 1'b1;
        idle(1);
        total++; if (valid !== 1'b0)     begin bad++; $display("FAIL b2b_drain got=%b exp=0", valid); end
        total++; if (out !== 8'h3C)      begin bad++; $display("FAIL b2b_hold got=%h exp=3c", out); end
        idle(50);
    endtask

    task automatic test_glitch();
        int v0 = n_valid, f0 = n_ferr, o0 = n_ovr;
        in = 1'b0;
        idle(40);
        in = 1'b1;
        idle(300);
        total++; if (n_valid - v0 !== 0) begin bad++; $display("FAIL glitch_nvalid got=%0d exp=0", n_valid - v0); end
        total++; if (n_ferr - f0 !== 0)  begin bad++; $display("FAIL glitch_ferr got=%0d exp=0", n_ferr - f0); end
        total++; if (n_ovr - o0 !== 0)   begin bad++; $display("FAIL glitch_ovr got=%0d exp=0", n_ovr - o0); end
    endtask

    task automatic test_frame_err();
        int v0 = n_valid, f0 = n_ferr;
        send_frame(8'hFF, 1'b0);
        idle(2000);
        total++; if (n_ferr - f0 !== 1)  begin bad++; $display("FAIL ferr_count got=%0d exp=1", n_ferr - f0); end
        total++; if (n_valid - v0 !== 0) begin bad++; $display("FAIL ferr_nvalid got=%0d exp=0", n_valid - v0); end
        in = 1'b1;
        idle(400);
        total++; if (n_ferr - f0 !== 1)  begin bad++; $display("FAIL ferr_recover_count got=%0d exp=1", n_ferr - f0); end
        total++; if (n_valid - v0 !== 0) begin bad++; $display("FAIL ferr_recover_nvalid got=%0d exp=0", n_valid - v0); end
        send_frame(8'h5A, 1'b1);
        idle(100);
        total++; if (n_valid - v0 !== 1) begin bad++; $display("FAIL ferr_next_nvalid got=%0d exp=1", n_valid - v0); end
        total++; if (last_out !== 8'h5A) begin bad++; $display("FAIL ferr_next_out got=%h exp=5a", last_out); end
    endtask

    task automatic test_reset_mid();
        int v0 = n_valid;
        hold_bit(1'b0);
        hold_bit(1'b1);
        hold_bit(1'b0);
        in    = 1'b1;
        reset = 1'b0;
        idle(3);
        total++; if (out !== 8'h00)      begin bad++; $display("FAIL rstmid_out got=%h exp=00", out); end
        total++; if (valid !== 1'b0)     begin bad++; $display("FAIL rstmid_valid got=%b exp=0", valid); end
        reset = 1'b1;
        idle(400);
        total++; if (n_valid - v0 !== 0) begin bad++; $display("FAIL rstmid_nvalid got=%0d exp=0", n_valid - v0); end
        send_frame(8'h01, 1'b1);
        idle(100);
        total++; if (n_valid - v0 !== 1) begin bad++; $display("FAIL rstmid_next_nvalid got=%0d exp=1", n_valid - v0); end
        total++; if (last_out !== 8'h01) begin bad++; $display("FAIL rstmid_next_out got=%h exp=01", last_out); end
    endtask

    task automatic test_en_abort();
        int v0 = n_valid, f0 = n_ferr;
        logic [7:0] d = 8'h55;
        hold_bit(1'b0);
        hold_bit(d[0]);
        en = 1'b0;
        for (int i = 1; i < 8; i++) hold_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        hold_bit(^d);
`endif
        hold_bit(1'b1);
        en = 1'b1;
        idle(200);
        total++; if (n_valid - v0 !== 0) begin bad++; $display("FAIL en_nvalid got=%0d exp=0", n_valid - v0); end
        total++; if (n_ferr - f0 !== 0)  begin bad++; $display("FAIL en_ferr got=%0d exp=0", n_ferr - f0); end
        total++; if (out !== 8'h01)      begin bad++; $display("FAIL en_hold_out got=%h exp=01", out); end
        send_frame(8'h01, 1'b1);
        idle(100);
        total++; if (n_valid - v0 !== 1) begin bad++; $display("FAIL en_next_nvalid got=%0d exp=1", n_valid - v0); end
        total++; if (last_out !== 8'h01) begin bad++; $display("FAIL en_next_out got=%h exp=01", last_out); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] d, input logic par);
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(d[i]);
        hold_bit(par);
        hold_bit(1'b1);
    endtask

    task automatic test_parity();
        int v0 = n_valid, p0 = n_perr;
        send_frame_par(8'h07, 1'b1);
        idle(100);
        total++; if (n_valid - v0 !== 1) begin bad++; $display("FAIL par_ok_nvalid got=%0d exp=1", n_valid - v0); end
        total++; if (last_out !== 8'h07) begin bad++; $display("FAIL par_ok_out got=%h exp=07", last_out); end
        total++; if (n_perr - p0 !== 0)  begin bad++; $display("FAIL par_ok_perr got=%0d exp=0", n_perr - p0); end
        send_frame_par(8'h07, 1'b0);
        idle(100);
        total++; if (n_perr - p0 !== 1)  begin bad++; $display("FAIL par_bad_perr got=%0d exp=1", n_perr - p0); end
        total++; if (n_valid - v0 !== 1) begin bad++; $display("FAIL par_bad_nvalid got=%0d exp=1", n_valid - v0); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        test_en_abort();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
